// File: rtl/reset_sequencer.sv
// reset_sequencer: turns ext_reset, PLL lock and a soft-reset request into
// NUM_OUTS active-low resets released one after another in the clk domain.
// Ports:
//   clk           sequencer clock (pixel clock)
//   ext_reset     asynchronous active-low reset
//   pll_lock      PLL lock, asynchronous to clk
//   soft_rst_req  one-cycle synchronous soft reset request
//   resetn_out    sequenced active-low resets, bit 0 released first
//   all_released  high once every resetn_out bit is high
//   reset_cause   0=ext/power, 1=lock loss, 2=soft request
// Build option: define RESET_SEQ_LOCK_FILTER_EN to require LOCK_FILTER
// consecutive synced-lock-high cycles before lock counts as good.
module reset_sequencer #(
    parameter int NUM_OUTS    = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int LOCK_FILTER = 64
) (
    input  logic                clk,
    input  logic                ext_reset,
    input  logic                pll_lock,
    input  logic                soft_rst_req,
    output logic [NUM_OUTS-1:0] resetn_out,
    output logic                all_released,
    output logic [1:0]          reset_cause
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ?
                             HOLD_CYCLES : STAGE_GAP;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int IW = $clog2(NUM_OUTS + 1);

    if (NUM_OUTS < 1) begin : g_bad_num_outs
        $error("NUM_OUTS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (HOLD_CYCLES < 1 || STAGE_GAP < 1) begin : g_bad_timing
        $error("HOLD_CYCLES and STAGE_GAP must be >= 1");
    end
    if (LOCK_FILTER < 1) begin : g_bad_filter
        $error("LOCK_FILTER must be >= 1");
    end

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] rst_chain;
    logic [SYNC_STAGES-1:0] lock_chain;
    logic                   rst_sync;
    logic                   lock_sync;
    logic                   lock_ok;

    // Both chains clear on ext_reset, so lock is always seen as
    // rising after reset release.
    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            rst_chain  <= '0;
            lock_chain <= '0;
        end else begin
            rst_chain  <= {rst_chain[SYNC_STAGES-2:0], 1'b1};
            lock_chain <= {lock_chain[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign rst_sync  = rst_chain[SYNC_STAGES-1];
    assign lock_sync = lock_chain[SYNC_STAGES-1];

`ifdef RESET_SEQ_LOCK_FILTER_EN
    localparam int FW = $clog2(LOCK_FILTER + 1);

    logic [FW-1:0] filt_cnt;

    // lock_ok rises on the LOCK_FILTER-th consecutive high sample;
    // any low sample restarts the run.
    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            filt_cnt <= '0;
            lock_ok  <= 1'b0;
        end else if (!lock_sync) begin
            filt_cnt <= '0;
            lock_ok  <= 1'b0;
        end else if (filt_cnt == FW'(LOCK_FILTER - 1)) begin
            lock_ok  <= 1'b1;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end
`else
    assign lock_ok = lock_sync;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            state        <= HOLD;
            cnt          <= '0;
            idx          <= '0;
            resetn_out   <= '0;
            all_released <= 1'b0;
            reset_cause  <= 2'd0;
        end else begin
            unique case (state)
                HOLD: begin
                    if (!(rst_sync && lock_ok)) begin
                        cnt <= '0;
                    end else if (cnt == CW'(HOLD_CYCLES)) begin
                        // HOLD_CYCLES qualifying cycles seen: release bit 0.
                        cnt        <= '0;
                        idx        <= IW'(1);
                        resetn_out <= NUM_OUTS'(1);
                        if (NUM_OUTS == 1) begin
                            state        <= RUN;
                            all_released <= 1'b1;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE, RUN: begin
                    if (!lock_ok || soft_rst_req) begin
                        // Lock loss takes priority over a soft request.
                        state        <= HOLD;
                        cnt          <= '0;
                        idx          <= '0;
                        resetn_out   <= '0;
                        all_released <= 1'b0;
                        reset_cause  <= !lock_ok ? 2'd1 : 2'd2;
                    end else if (state == RELEASE) begin
                        if (cnt == CW'(STAGE_GAP - 1)) begin
                            cnt        <= '0;
                            idx        <= idx + 1'b1;
                            resetn_out <= resetn_out |
                                          (NUM_OUTS'(1) << idx);
                            if (idx == IW'(NUM_OUTS - 1)) begin
                                state        <= RUN;
                                all_released <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for reset_sequencer at default
// parameters, one task per scenario, expected edges computed by hand.
module tb_reset_sequencer;

    localparam int S = 2;
    localparam int H = 16;
    localparam int G = 8;
`ifdef RESET_SEQ_LOCK_FILTER_EN
    localparam int FEFF = 64;
    localparam int FD   = 1;
`else
    localparam int FEFF = 0;
    localparam int FD   = 0;
`endif

    logic       clk = 1'b0;
    logic       ext_reset;
    logic       pll_lock;
    logic       soft_rst_req;
    logic [2:0] resetn_out;
    logic       all_released;
    logic [1:0] reset_cause;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .clk          (clk),
        .ext_reset    (ext_reset),
        .pll_lock     (pll_lock),
        .soft_rst_req (soft_rst_req),
        .resetn_out   (resetn_out),
        .all_released (all_released),
        .reset_cause  (reset_cause)
    );

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (resetn_out !== 3'b000) begin
            errors++;
            $display("FAIL reset_out: got %b want 000", resetn_out);
        end
        vectors++;
        if (all_released !== 1'b0) begin
            errors++;
            $display("FAIL reset_all: got %b want 0", all_released);
        end
        vectors++;
        if (reset_cause !== 2'd0) begin
            errors++;
            $display("FAIL reset_cause: got %0d want 0", reset_cause);
        end
    endtask

    // Release ext_reset so the next posedge is edge 0; out[i] at
    // S+H+i*G (+FEFF with the lock filter): 18, 26, 34.
    task automatic test_power_on(input string nm);
        logic [2:0] exp;
        @(posedge clk);
        #1;
        ext_reset = 1'b1;
        for (int k = 0; k <= 38 + FEFF; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++)
                exp[i] = (k >= S + H + FEFF + i * G);
            vectors++;
            if (resetn_out !== exp) begin
                errors++;
                $display("FAIL %s_out edge %0d: got %b want %b",
                         nm, k, resetn_out, exp);
            end
            vectors++;
            if (all_released !== exp[2]) begin
                errors++;
                $display("FAIL %s_all edge %0d: got %b want %b",
                         nm, k, all_released, exp[2]);
            end
            vectors++;
            if (reset_cause !== 2'd0) begin
                errors++;
                $display("FAIL %s_cause edge %0d: got %0d want 0",
                         nm, k, reset_cause);
            end
        end
    endtask

    // Abort at edge E; first count at E+1, out[i] at E+H+1+i*G.
    // A soft pulse during HOLD must not move those edges.
    task automatic test_soft();
        logic [2:0] exp;
        soft_rst_req = 1'b1;
        @(posedge clk);
        #1;
        soft_rst_req = 1'b0;
        vectors++;
        if (resetn_out !== 3'b000 || all_released !== 1'b0) begin
            errors++;
            $display("FAIL soft_abort: got out=%b all=%b want 000/0",
                     resetn_out, all_released);
        end
        vectors++;
        if (reset_cause !== 2'd2) begin
            errors++;
            $display("FAIL soft_cause: got %0d want 2", reset_cause);
        end
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++)
                exp[i] = (k >= H + 1 + i * G);
            vectors++;
            if (resetn_out !== exp || all_released !== exp[2]) begin
                errors++;
                $display("FAIL soft_seq edge %0d: got %b/%b want %b/%b",
                         k, resetn_out, all_released, exp, exp[2]);
            end
            soft_rst_req = (k == 5);
        end
        soft_rst_req = 1'b0;
    endtask

    task automatic test_ext_async();
        @(posedge clk);
        #2;
        ext_reset = 1'b0;
        #1;
        vectors++;
        if (resetn_out !== 3'b000 || all_released !== 1'b0) begin
            errors++;
            $display("FAIL ext_async: got out=%b all=%b want 000/0",
                     resetn_out, all_released);
        end
        vectors++;
        if (reset_cause !== 2'd0) begin
            errors++;
            $display("FAIL ext_cause: got %0d want 0", reset_cause);
        end
        test_power_on("replay");
    endtask

    // Get to 001 via a soft reset, drop lock after edge P for 5 cycles.
    // Abort at P+3 (+FD); release again at P+24 (+FEFF).
    task automatic test_lock_loss();
        logic [2:0] exp;
        logic [1:0] expc;
        soft_rst_req = 1'b1;
        @(posedge clk);
        #1;
        soft_rst_req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (resetn_out !== 3'b001) begin
            errors++;
            $display("FAIL lock_setup: got %b want 001", resetn_out);
        end
        pll_lock = 1'b0;
        for (int k = 1; k <= 42 + FEFF; k++) begin
            @(posedge clk);
            #1;
            if (k < 3 + FD) begin
                exp  = 3'b001;
                expc = 2'd2;
            end else begin
                for (int i = 0; i < 3; i++)
                    exp[i] = (k >= 24 + FEFF + i * G);
                expc = 2'd1;
            end
            vectors++;
            if (resetn_out !== exp || all_released !== exp[2]) begin
                errors++;
                $display("FAIL lock_seq edge %0d: got %b/%b want %b/%b",
                         k, resetn_out, all_released, exp, exp[2]);
            end
            vectors++;
            if (reset_cause !== expc) begin
                errors++;
                $display("FAIL lock_cause edge %0d: got %0d want %0d",
                         k, reset_cause, expc);
            end
            if (k == 5) pll_lock = 1'b1;
        end
    endtask

    task automatic test_both();
        pll_lock = 1'b0;
        repeat (2 + FD) @(posedge clk);
        #1;
        soft_rst_req = 1'b1;
        @(posedge clk);
        #1;
        soft_rst_req = 1'b0;
        vectors++;
        if (resetn_out !== 3'b000 || reset_cause !== 2'd1) begin
            errors++;
            $display("FAIL both_abort: got out=%b cause=%0d want 000/1",
                     resetn_out, reset_cause);
        end
        pll_lock = 1'b1;
        for (int k = 0; k < 120 + FEFF; k++) begin
            @(posedge clk);
            #1;
            if (all_released === 1'b1) break;
        end
        vectors++;
        if (all_released !== 1'b1 || reset_cause !== 2'd1) begin
            errors++;
            $display("FAIL both_recover: got all=%b cause=%0d want 1/1",
                     all_released, reset_cause);
        end
    endtask

    // Lock toggling every 10 cycles never releases; a steady lock rising
    // after edge T0 releases out[0] at T0+S+1+FEFF+H.
    task automatic test_lock_filter();
        int lat;
        lat = S + 1 + FEFF + H;
        ext_reset = 1'b0;
        pll_lock  = 1'b0;
        @(posedge clk);
        #1;
        ext_reset = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (resetn_out !== 3'b000) begin
                errors++;
                $display("FAIL toggle_hold edge %0d: got %b want 000",
                         k, resetn_out);
            end
            if (k % 10 == 9) pll_lock = ~pll_lock;
        end
        repeat (5) @(posedge clk);
        #1;
        pll_lock = 1'b1;
        for (int k = 1; k <= lat + 2; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (resetn_out !== ((k >= lat) ? 3'b001 : 3'b000)) begin
                errors++;
                $display("FAIL steady_lock edge %0d: got %b want %b",
                         k, resetn_out,
                         (k >= lat) ? 3'b001 : 3'b000);
            end
        end
    endtask

    initial begin
        ext_reset    = 1'b0;
        pll_lock     = 1'b1;
        soft_rst_req = 1'b0;
        test_reset();
        test_power_on("power_on");
        test_soft();
        test_ext_async();
        test_lock_loss();
        test_both();
        test_lock_filter();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
